demux_registrado: RTL and testbench

- Parametrised, clocked successor to the combinational 1-to-5 operand demultiplexer in the multiplier datapath.
- Routes a WIDTH-bit input word to one of N_SAIDAS held output registers, selected by op. Replaces combinational hold-by-feedback with real registers.
- Adds a broadcast mode, per-channel "new data" flags with consumer acknowledge, an out-of-range error flag and a saturating write counter.
- Sits between the operand source and the multiplier/accumulator registers.

---
 rtl/demux_registrado.sv | 94 +++++++++
 tb/tb_demux_registrado.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_registrado.sv
// Registered 1-to-N operand demultiplexer. Routes a data word into one of
// N_SAIDAS held channel registers, or into all of them in broadcast mode.
// Tracks per-channel new-data flags, a sticky bad-index flag and a
// saturating count of accepted writes.
module demux_registrado #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned N_SAIDAS = 5,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [SEL_W-1:0]          op,
    input  logic [WIDTH-1:0]          entrada,
    input  logic                      valido,
    input  logic                      difunde,
    input  logic [N_SAIDAS-1:0]       lido,
    input  logic                      limpa_erro,
    output logic [N_SAIDAS*WIDTH-1:0] saidas,
    output logic [N_SAIDAS-1:0]       novo,
    output logic                      erro_op,
    output logic [CNT_W-1:0]          contagem
);

    logic [N_SAIDAS*WIDTH-1:0] saidas_q, saidas_d;
    logic [N_SAIDAS-1:0]       novo_q, novo_d;
    logic                      erro_q, erro_d;
    logic [CNT_W-1:0]          contagem_q, contagem_d;

    logic [31:0]         op_ext;
    logic                op_ok;
    logic                escrita;
    logic                erro_set;
    logic [N_SAIDAS-1:0] carga;

    // Decode the request into per-channel load enables and write/error events.
    always_comb begin
        op_ext   = 32'(op);
        op_ok    = op_ext < 32'(N_SAIDAS);
        escrita  = valido && (difunde || op_ok);
        // Broadcast ignores op, so it can never raise the error.
        erro_set = valido && !difunde && !op_ok;
        carga    = '0;
        for (int unsigned k = 0; k < N_SAIDAS; k++) begin
            carga[k] = valido && (difunde || (op_ok && (op_ext == 32'(k))));
        end
    end

    // Next-state: load selected channels, flag updates, saturating count.
    always_comb begin
        saidas_d = saidas_q;
        for (int unsigned k = 0; k < N_SAIDAS; k++) begin
            if (carga[k]) begin
                saidas_d[k*WIDTH +: WIDTH] = entrada;
            end
        end
        // A write in the same cycle overrides the acknowledge.
        novo_d = (novo_q & ~lido) | carga;
        // A new error overrides the clear request.
        if (erro_set) begin
            erro_d = 1'b1;
        end else if (limpa_erro) begin
            erro_d = 1'b0;
        end else begin
            erro_d = erro_q;
        end
        if (escrita && (contagem_q != {CNT_W{1'b1}})) begin
            contagem_d = contagem_q + CNT_W'(1);
        end else begin
            contagem_d = contagem_q;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saidas_q   <= '0;
            novo_q     <= '0;
            erro_q     <= 1'b0;
            contagem_q <= '0;
        end else begin
            saidas_q   <= saidas_d;
            novo_q     <= novo_d;
            erro_q     <= erro_d;
            contagem_q <= contagem_d;
        end
    end

    assign saidas   = saidas_q;
    assign novo     = novo_q;
    assign erro_op  = erro_q;
    assign contagem = contagem_q;

endmodule

// File: tb/tb_demux_registrado.sv
// Scoreboard bench for demux_registrado: each stimulus step pushes the
// hand-derived expected state; a monitor pops and compares after each edge.
module tb_demux_registrado;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned N_SAIDAS = 5;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned CNT_W    = 3;

    logic                      clock;
    logic                      reset;
    logic [SEL_W-1:0]          op;
    logic [WIDTH-1:0]          entrada;
    logic                      valido;
    logic                      difunde;
    logic [N_SAIDAS-1:0]       lido;
    logic                      limpa_erro;
    logic [N_SAIDAS*WIDTH-1:0] saidas;
    logic [N_SAIDAS-1:0]       novo;
    logic                      erro_op;
    logic [CNT_W-1:0]          contagem;

    demux_registrado #(
        .WIDTH   (WIDTH),
        .N_SAIDAS(N_SAIDAS),
        .SEL_W   (SEL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .op        (op),
        .entrada   (entrada),
        .valido    (valido),
        .difunde   (difunde),
        .lido      (lido),
        .limpa_erro(limpa_erro),
        .saidas    (saidas),
        .novo      (novo),
        .erro_op   (erro_op),
        .contagem  (contagem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string                     name;
        logic [N_SAIDAS*WIDTH-1:0] sai;
        logic [N_SAIDAS-1:0]       nov;
        logic                      err;
        logic [CNT_W-1:0]          cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected state, edited by hand before each step.
    logic [WIDTH-1:0]    exp_ch[N_SAIDAS];
    logic [N_SAIDAS-1:0] exp_novo;
    logic                exp_err;
    logic [CNT_W-1:0]    exp_cnt;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] req);
        n_checks++;
        if (got === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    function automatic logic [N_SAIDAS*WIDTH-1:0] pack_exp();
        logic [N_SAIDAS*WIDTH-1:0] v;
        for (int k = 0; k < N_SAIDAS; k++) v[k*WIDTH +: WIDTH] = exp_ch[k];
        return v;
    endfunction

    task automatic clear_exp();
        for (int k = 0; k < N_SAIDAS; k++) exp_ch[k] = '0;
        exp_novo = '0;
        exp_err  = 1'b0;
        exp_cnt  = '0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".saidas"}, 128'(saidas), 128'd0);
        chk({nm, ".novo"}, 128'(novo), 128'd0);
        chk({nm, ".erro"}, 128'(erro_op), 128'd0);
        chk({nm, ".cnt"}, 128'(contagem), 128'd0);
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge state.
    task automatic step(input string nm, input logic v, input logic d, input logic [SEL_W-1:0] o,
                        input logic [WIDTH-1:0] e, input logic [N_SAIDAS-1:0] l,
                        input logic le);
        exp_t x;
        @(negedge clock);
        valido = v; difunde = d; op = o; entrada = e; lido = l; limpa_erro = le;
        x.name = nm;
        x.sai  = pack_exp();
        x.nov  = exp_novo;
        x.err  = exp_err;
        x.cnt  = exp_cnt;
        q.push_back(x);
    endtask

    task automatic idle_inputs();
        valido = 1'b0; difunde = 1'b0; op = '0; entrada = '0; lido = '0; limpa_erro = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        #1;
        chk_zero(nm);
        clear_exp();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: compare queued expectations shortly after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk({x.name, ".saidas"}, 128'(saidas), 128'(x.sai));
                chk({x.name, ".novo"}, 128'(novo), 128'(x.nov));
                chk({x.name, ".erro"}, 128'(erro_op), 128'(x.err));
                chk({x.name, ".cnt"}, 128'(contagem), 128'(x.cnt));
            end
        end
    end

    initial begin
        idle_inputs();
        clear_exp();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk_zero("rst_async");
        // Inputs toggling during reset must not be captured.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            valido = 1'b1; difunde = i[0]; op = 3'(i + 1); entrada = 16'hFFFF - 16'(i);
            lido = 5'b11111; limpa_erro = 1'b0;
            @(posedge clock);
            #1;
            chk_zero("rst_hold");
        end
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;

        // First write after reset.
        exp_ch[2] = 16'h1234; exp_novo = 5'b00100; exp_cnt = 3'd1;
        step("first_wr", 1, 0, 3'd2, 16'h1234, 5'b0, 0);

        // Hold / sequence.
        do_reset("rst_seq");
        exp_ch[0] = 16'hAAAA; exp_novo = 5'b00001; exp_cnt = 3'd1;
        step("wr_ch0", 1, 0, 3'd0, 16'hAAAA, 5'b0, 0);
        exp_ch[4] = 16'h5555; exp_novo = 5'b10001; exp_cnt = 3'd2;
        step("wr_ch4", 1, 0, 3'd4, 16'h5555, 5'b0, 0);
        for (int i = 0; i < 3; i++) step("idle_hold", 0, 0, 3'd1, 16'h7777, 5'b0, 0);

        // Broadcast with an out-of-range op.
        for (int k = 0; k < N_SAIDAS; k++) exp_ch[k] = 16'hBEEF;
        exp_novo = 5'b11111; exp_cnt = 3'd3;
        step("bcast", 1, 1, 3'd7, 16'hBEEF, 5'b0, 0);

        // Invalid op, set-wins-over-clear, then clear.
        exp_err = 1'b1;
        step("bad_op5", 1, 0, 3'd5, 16'h1111, 5'b0, 0);
        step("bad_op6_clr", 1, 0, 3'd6, 16'h2222, 5'b0, 1);
        exp_err = 1'b0;
        step("clr_err", 0, 0, 3'd0, 16'h0, 5'b0, 1);

        // Acknowledge colliding with a write, then acknowledge alone.
        exp_ch[1] = 16'h0F0F; exp_cnt = 3'd4;
        step("ack_coll", 1, 0, 3'd1, 16'h0F0F, 5'b00010, 0);
        exp_novo = 5'b11101;
        step("ack_only", 0, 0, 3'd1, 16'hFFFF, 5'b00010, 0);

        // Saturation of a 3-bit counter across 10 writes.
        do_reset("rst_sat");
        for (int k = 0; k < 10; k++) begin
            exp_ch[k % 5]   = 16'h0100 + 16'(k);
            exp_novo[k % 5] = 1'b1;
            exp_cnt         = (k + 1 > 7) ? 3'd7 : 3'(k + 1);
            step("sat_wr", 1, 0, 3'(k % 5), 16'h0100 + 16'(k), 5'b0, 0);
        end

        // Reset asserted while a write is pending.
        @(negedge clock);
        valido = 1'b1; difunde = 1'b1; op = 3'd0; entrada = 16'hDEAD;
        #2;
        reset = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(posedge clock);
        #1;
        chk_zero("rst_mid_edge");
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clock);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending, required 0", q.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
